// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to instruction
// memory and buffers {pc, inst} pairs in a small FIFO drained by decode.
// A redirect from execute flushes the FIFO and restarts fetch at the target.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q;
  logic [PW:0]   count_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic push;
  logic pop;

  // Request and handshake decode; redirect kills both the request and any pop.
  always_comb begin
    imem_req   = !rst && !redirect && (count_q != FULL);
    imem_addr  = fetch_pc_q;
    inst_valid = (count_q != '0);
    push       = imem_req && imem_ack;
    pop        = inst_valid && inst_ready && !redirect;
    inst       = inst_valid ? inst_mem[rd_ptr_q] : 32'h0;
    inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : 32'h0;
  end

  // Queue storage; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      inst_mem[wr_ptr_q] <= imem_data;
    end
  end

  // Control state: reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else if (redirect) begin
      fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed testbench for inst_fetch_queue. Inputs change on the falling edge,
// outputs are sampled on the falling edge before inputs are updated.
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int n_cmp;
  int n_err;

  // Memory model returns the word index of the requested address.
  assign imem_data = {2'b00, imem_addr[31:2]};

  inst_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0; inst_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0; inst_ready = 1'b0;
    step();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got=%h exp=0", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", inst_pc); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL release_req got=%0b exp=1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL release_addr got=%h exp=0", imem_addr); end
  endtask

  // Sustained 1/cycle streaming; 16 pushes wrap the pointers four times.
  task automatic test_stream();
    do_reset();
    imem_ack = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst !== 32'(i)) begin
        n_err++;
        $display("FAIL stream[%0d] got v=%0b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                 i, inst_valid, inst_pc, inst, 32'(4 * i), 32'(i));
      end
    end
    imem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_ack = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_full_req got=%0b exp=0", imem_req); end
    n_cmp++; if (imem_addr !== 32'd16) begin n_err++; $display("FAIL bp_full_addr got=%h exp=10", imem_addr); end
    n_cmp++; if (inst_pc !== 32'd0) begin n_err++; $display("FAIL bp_head got=%h exp=0", inst_pc); end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL bp_req_rise got=%0b exp=1", imem_req); end
    n_cmp++; if (inst_pc !== 32'd4) begin n_err++; $display("FAIL bp_pop got=%h exp=4", inst_pc); end
    step();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_refull got=%0b exp=0", imem_req); end
    n_cmp++; if (imem_addr !== 32'd20) begin n_err++; $display("FAIL bp_addr20 got=%h exp=14", imem_addr); end
    imem_ack = 1'b0; inst_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++;
      if (inst_pc !== 32'(4 + 4 * k)) begin
        n_err++; $display("FAIL bp_drain[%0d] got=%h exp=%h", k, inst_pc, 32'(4 + 4 * k));
      end
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    imem_ack = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    inst_ready = 1'b1;
    step();
    step();
    n_cmp++; if (inst_pc !== 32'd8) begin n_err++; $display("FAIL rd_setup_head got=%h exp=8", inst_pc); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rd_req_kill got=%0b exp=0", imem_req); end
    step();
    redirect = 1'b0; inst_ready = 1'b0;
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rd_flush got=%0b exp=0", inst_valid); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL rd_addr got=%h exp=100", imem_addr); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rd_req got=%0b exp=1", imem_req); end
    step();
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== 32'h40) begin
      n_err++;
      $display("FAIL rd_target got v=%0b pc=%h inst=%h exp v=1 pc=100 inst=40", inst_valid, inst_pc, inst);
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_push_pop();
    do_reset();
    imem_ack = 1'b1; inst_ready = 1'b0;
    step();
    step();
    inst_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k)) begin
        n_err++; $display("FAIL pp_head[%0d] got v=%0b pc=%h exp pc=%h", k, inst_valid, inst_pc, 32'(4 * k));
      end
      n_cmp++;
      if (imem_addr !== 32'(4 * k + 8)) begin
        n_err++; $display("FAIL pp_addr[%0d] got=%h exp=%h", k, imem_addr, 32'(4 * k + 8));
      end
    end
    imem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_wrap_pc();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_tgt got=%h exp=fffffffc", imem_addr); end
    imem_ack = 1'b1;
    step();
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    n_cmp++;
    if (inst_pc !== 32'hFFFF_FFFC || inst !== 32'h3FFF_FFFF) begin
      n_err++; $display("FAIL wrap_head got pc=%h inst=%h exp pc=fffffffc inst=3fffffff", inst_pc, inst);
    end
    step();
    imem_ack = 1'b0; inst_ready = 1'b1;
    step();
    n_cmp++; if (inst_pc !== 32'h0 || inst !== 32'h0) begin n_err++; $display("FAIL wrap_next got pc=%h inst=%h exp 0/0", inst_pc, inst); end
    inst_ready = 1'b0;
  endtask

  // Irregular ack/ready pattern against a reference queue model.
  task automatic test_ptr_wrap();
    logic [31:0] q[$];
    logic [31:0] fpc;
    logic        req;
    logic        ack;
    logic        rdy;
    do_reset();
    fpc = 32'h0;
    for (int k = 0; k < 40; k++) begin
      ack = (k % 3) != 2;
      rdy = (k % 5) > 1;
      imem_ack = ack; inst_ready = rdy;
      req = (q.size() < 4);
      step();
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (req && ack) begin q.push_back(fpc); fpc = fpc + 32'd4; end
      n_cmp++;
      if (inst_valid !== (q.size() != 0) || imem_addr !== fpc ||
          (q.size() != 0 && inst_pc !== q[0]) || imem_req !== (q.size() < 4)) begin
        n_err++;
        $display("FAIL ptr_wrap[%0d] got v=%0b pc=%h addr=%h req=%0b exp v=%0b pc=%h addr=%h req=%0b",
                 k, inst_valid, inst_pc, imem_addr, imem_req, q.size() != 0,
                 (q.size() != 0) ? q[0] : 32'h0, fpc, q.size() < 4);
      end
    end
    imem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_reset_redirect();
    do_reset();
    imem_ack = 1'b1;
    step();
    step();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rr_valid got=%0b exp=0", inst_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rr_req got=%0b exp=0", imem_req); end
    rst = 1'b0; redirect = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rr_addr got=%h exp=0", imem_addr); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rr_req_rel got=%0b exp=1", imem_req); end
    imem_ack = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_push_pop();
    test_wrap_pc();
    test_ptr_wrap();
    test_reset_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
